// File: rtl/fir_pkg.sv
// Shared constants and width helpers for the pipelined FIR filter.
package fir_pkg;

  localparam int unsigned DEF_NTAPS  = 5;
  localparam int unsigned DEF_COEF_W = 4;

  // Tap 0 sits in the least-significant coefficient slot.
  localparam logic [DEF_NTAPS*DEF_COEF_W-1:0] COEF_INIT_DEF = {4'd1, 4'd2, 4'd3, 4'd2, 4'd1};

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned ntaps);
    return data_w + coef_w + clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_pipe_param_if.sv
// Sample stream, coefficient programming and result signals of the FIR filter.
interface fir_pipe_param_if
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS  = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 4,
  parameter int unsigned OUT_W  = 12
);

  localparam int unsigned ADDR_W = clog2(NTAPS);

  logic              in_valid;
  logic [DATA_W-1:0] data_in;
  logic              coef_we;
  logic [ADDR_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              coef_commit;
  logic              out_valid;
  logic [OUT_W-1:0]  data_out;
  logic              sat;

  modport master (
    output in_valid, data_in, coef_we, coef_addr, coef_wdata, coef_commit,
    input  out_valid, data_out, sat
  );

  modport slave (
    input  in_valid, data_in, coef_we, coef_addr, coef_wdata, coef_commit,
    output out_valid, data_out, sat
  );

endinterface

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: writes land in the shadow bank and a
// commit copies it into the active bank used by the multipliers.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS  = 5,
  parameter int unsigned COEF_W = 4,
  parameter logic [NTAPS*COEF_W-1:0] COEF_INIT = COEF_INIT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [clog2(NTAPS)-1:0]    addr,
  input  logic [COEF_W-1:0]          wdata,
  input  logic                       commit,
  output logic [NTAPS*COEF_W-1:0]    active
);

  localparam int unsigned ADDR_W = clog2(NTAPS);

  logic [COEF_W-1:0] shadow      [NTAPS];
  logic [COEF_W-1:0] shadow_next [NTAPS];
  logic [COEF_W-1:0] act         [NTAPS];

  // Addresses at or beyond NTAPS match no slot and are dropped.
  always_comb begin
    for (int unsigned i = 0; i < NTAPS; i++) begin
      shadow_next[i] = shadow[i];
      if (we && (addr == ADDR_W'(i))) shadow_next[i] = wdata;
    end
  end

  // Committing from shadow_next folds a same-cycle write into the new bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        shadow[i] <= COEF_INIT[i*COEF_W +: COEF_W];
        act[i]    <= COEF_INIT[i*COEF_W +: COEF_W];
      end
    end else begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        shadow[i] <= shadow_next[i];
        if (commit) act[i] <= shadow_next[i];
      end
    end
  end

  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < NTAPS; i++) active[i*COEF_W +: COEF_W] = act[i];
  end

endmodule

// File: rtl/fir_pipe_param.sv
// Three-stage FIR: tap shift register, parallel product register, then a
// saturating adder-tree output register.
module fir_pipe_param
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS  = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 4,
  parameter int unsigned OUT_W  = 12,
  parameter logic [NTAPS*COEF_W-1:0] COEF_INIT = COEF_INIT_DEF
) (
  input logic             clk,
  input logic             rst,
  fir_pipe_param_if.slave bus
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);

  logic [NTAPS*COEF_W-1:0] coef_flat;
  logic [DATA_W-1:0]       tap  [NTAPS];
  logic [PROD_W-1:0]       prod [NTAPS];
  logic                    v1;
  logic                    v2;
  logic [ACC_W-1:0]        sum;
  logic [OUT_W-1:0]        sum_clip;
  logic                    sum_over;
  logic                    out_valid_q;
  logic [OUT_W-1:0]        data_out_q;
  logic                    sat_q;

  fir_coef_bank #(
    .NTAPS    (NTAPS),
    .COEF_W   (COEF_W),
    .COEF_INIT(COEF_INIT)
  ) u_coef_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.coef_we),
    .addr  (bus.coef_addr),
    .wdata (bus.coef_wdata),
    .commit(bus.coef_commit),
    .active(coef_flat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NTAPS; i++) tap[i] <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        tap[0] <= bus.data_in;
        for (int unsigned i = 1; i < NTAPS; i++) tap[i] <= tap[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NTAPS; i++) prod[i] <= '0;
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      for (int unsigned i = 0; i < NTAPS; i++)
        prod[i] <= PROD_W'(tap[i]) * PROD_W'(coef_flat[i*COEF_W +: COEF_W]);
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NTAPS; i++) sum = sum + ACC_W'(prod[i]);
  end

  // Clipping only exists when the accumulator is wider than the output.
  generate
    if (ACC_W > OUT_W) begin : g_clip
      assign sum_over = |sum[ACC_W-1:OUT_W];
      assign sum_clip = sum_over ? '1 : sum[OUT_W-1:0];
    end else begin : g_wide
      assign sum_over = 1'b0;
      assign sum_clip = OUT_W'(sum);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      out_valid_q <= v2;
      if (v2) begin
        data_out_q <= sum_clip;
        sat_q      <= sum_over;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_fir_pipe_param.sv
// Two filter instances (12-bit and 10-bit outputs) share one stimulus stream
// and are compared each cycle against a history/coefficient-array model.
module tb_fir_pipe_param;

  localparam int unsigned NT  = 5;
  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned OW1 = 12;
  localparam int unsigned OW2 = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_pipe_param_if #(.NTAPS(NT), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW1)) bus1 ();
  fir_pipe_param_if #(.NTAPS(NT), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW2)) bus2 ();

  fir_pipe_param #(.NTAPS(NT), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW1)) dut (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  fir_pipe_param #(.NTAPS(NT), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  typedef struct {
    bit          v;
    int unsigned sum;
  } res_t;

  int unsigned hist     [NT];
  int unsigned shadow_m [NT];
  int unsigned active_m [NT];
  int unsigned init_c   [NT] = '{1, 2, 3, 2, 1};
  res_t        pipe     [$];
  bit          exp_v;
  int unsigned exp_sum;

  bit          cur_v, cur_we, cur_cm;
  int unsigned cur_d, cur_a, cur_w;

  logic [31:0] got1 [$];
  logic [31:0] got2 [$];

  int errors = 0;
  int checks = 0;

  function automatic int unsigned clipw(input int unsigned s, input int unsigned w);
    int unsigned m;
    m = (32'd1 << w) - 1;
    return (s > m) ? m : s;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q [$], input int k);
    return (k < q.size()) ? q[k] : 32'hxxxx_xxxx;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      hist[i]     = 0;
      shadow_m[i] = init_c[i];
      active_m[i] = init_c[i];
    end
    pipe.delete();
    pipe.push_back('{v: 1'b0, sum: 0});
    pipe.push_back('{v: 1'b0, sum: 0});
    exp_v   = 1'b0;
    exp_sum = 0;
  endtask

  // A sample accepted on an edge is filtered with the coefficients committed
  // up to and including that edge and shows up two edges later.
  task automatic model_edge();
    res_t r;
    int unsigned s;
    if (cur_we && cur_a < NT) shadow_m[cur_a] = cur_w;
    if (cur_cm) for (int i = 0; i < NT; i++) active_m[i] = shadow_m[i];
    if (cur_v) begin
      for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = cur_d;
    end
    s = 0;
    for (int i = 0; i < NT; i++) s += hist[i] * active_m[i];
    pipe.push_back('{v: cur_v, sum: s});
    r = pipe.pop_front();
    exp_v = r.v;
    if (r.v) exp_sum = r.sum;
  endtask

  task automatic compare_all();
    check("out_valid12", {31'd0, bus1.out_valid}, {31'd0, exp_v});
    check("data_out12",  32'(bus1.data_out), clipw(exp_sum, OW1));
    check("sat12",       {31'd0, bus1.sat}, (exp_sum > clipw(exp_sum, OW1)) ? 32'd1 : 32'd0);
    check("out_valid10", {31'd0, bus2.out_valid}, {31'd0, exp_v});
    check("data_out10",  32'(bus2.data_out), clipw(exp_sum, OW2));
    check("sat10",       {31'd0, bus2.sat}, (exp_sum > clipw(exp_sum, OW2)) ? 32'd1 : 32'd0);
  endtask

  task automatic drive(input bit v, input int unsigned d, input bit we,
                       input int unsigned a, input int unsigned w, input bit cm);
    cur_v = v; cur_d = d; cur_we = we; cur_a = a; cur_w = w; cur_cm = cm;
    bus1.in_valid = v;  bus1.data_in = DW'(d);  bus1.coef_we = we;
    bus1.coef_addr = 3'(a); bus1.coef_wdata = CW'(w); bus1.coef_commit = cm;
    bus2.in_valid = v;  bus2.data_in = DW'(d);  bus2.coef_we = we;
    bus2.coef_addr = 3'(a); bus2.coef_wdata = CW'(w); bus2.coef_commit = cm;
  endtask

  task automatic step(input bit v, input int unsigned d, input bit we,
                      input int unsigned a, input int unsigned w, input bit cm);
    drive(v, d, we, a, w, cm);
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (bus1.out_valid === 1'b1) got1.push_back(32'(bus1.data_out));
    if (bus2.out_valid === 1'b1) got2.push_back(32'(bus2.data_out));
  endtask

  task automatic do_reset(input string tag);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check({tag, "_ov"},  {31'd0, bus1.out_valid}, 32'd0);
    check({tag, "_do"},  32'(bus1.data_out), 32'd0);
    check({tag, "_sat"}, {31'd0, bus1.sat}, 32'd0);
    check({tag, "_do10"}, 32'(bus2.data_out), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    got1.delete();
    got2.delete();
  endtask

  int unsigned imp_exp [5] = '{10, 20, 30, 20, 10};
  int unsigned rst_exp [5] = '{5, 10, 15, 10, 5};

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    model_reset();

    // Power-on reset.
    do_reset("por");

    // Impulse with defaults, including first-result latency.
    step(1, 10, 0, 0, 0, 0);
    check("imp_lat_e0", {31'd0, bus1.out_valid}, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    check("imp_lat_e1", {31'd0, bus1.out_valid}, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    check("imp_lat_e2", {31'd0, bus1.out_valid}, 32'd1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) check($sformatf("imp_seq%0d", k), qget(got1, k), imp_exp[k]);
    check("imp_tail", qget(got1, 5), 32'd0);

    // Bubbles: in_valid alternates, idle data is garbage and must be ignored.
    do_reset("rst_bub");
    step(1, 10, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, $urandom_range(255), 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
    end
    for (int k = 0; k < 5; k++) check($sformatf("bub_seq%0d", k), qget(got1, k), imp_exp[k]);

    // Saturation: 255 * 9 = 2295 fits 12 bits, clips to 1023 at 10 bits.
    do_reset("rst_sat");
    for (int i = 0; i < 10; i++) step(1, 255, 0, 0, 0, 0);
    check("sat_do10",  32'(bus2.data_out), 32'd1023);
    check("sat_flag10", {31'd0, bus2.sat}, 32'd1);
    check("sat_do12",  32'(bus1.data_out), 32'd2295);
    check("sat_flag12", {31'd0, bus1.sat}, 32'd0);

    // Coefficient swap through the shadow bank.
    do_reset("rst_coef");
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0, 0);
    check("coef_base", 32'(bus1.data_out), 32'd9);
    for (int a = 0; a < 5; a++) step(1, 1, 1, a, 4, 0);
    step(1, 1, 1, 6, 15, 0);
    check("coef_shadow_only", 32'(bus1.data_out), 32'd9);
    step(1, 1, 0, 0, 0, 1);
    check("coef_commit_e0", 32'(bus1.data_out), 32'd9);
    step(1, 1, 0, 0, 0, 0);
    check("coef_commit_e1", 32'(bus1.data_out), 32'd9);
    step(1, 1, 0, 0, 0, 0);
    check("coef_commit_e2", 32'(bus1.data_out), 32'd20);
    step(1, 1, 1, 0, 7, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check("coef_wr_commit", 32'(bus1.data_out), 32'd23);
    step(1, 1, 1, 5, 15, 1);
    step(1, 1, 1, 7, 15, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    check("coef_oob_ignored", 32'(bus1.data_out), 32'd23);

    // Reset while results are streaming; coefficients must revert.
    for (int i = 0; i < 3; i++) step(1, $urandom_range(255), 0, 0, 0, 0);
    check("mid_ov_before", {31'd0, bus1.out_valid}, 32'd1);
    do_reset("rst_mid");
    step(1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) check($sformatf("mid_seq%0d", k), qget(got1, k), rst_exp[k]);

    // Randomized traffic with interleaved coefficient programming.
    do_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) != 0, $urandom_range(255),
           $urandom_range(3) == 0, $urandom_range(7), $urandom_range(15),
           $urandom_range(7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_pipe_param.md
FIR_PIPE_PARAM -- requirements
Module: fir_pipe_param

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NTAPS, 5, number of taps, 2..32.
- DATA_W, 8, unsigned input sample width.
- COEF_W, 4, unsigned coefficient width.
- OUT_W, 12, unsigned output width.
- COEF_INIT, {1,2,3,2,1}, reset coefficients, tap 0 first.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, data_in is a new sample this cycle.
- data_in, in, DATA_W, input sample.
- coef_we, in, 1, write coef_wdata into the shadow bank.
- coef_addr, in, clog2(NTAPS), shadow tap index.
- coef_wdata, in, COEF_W, coefficient value.
- coef_commit, in, 1, copy the shadow bank into the active bank.
- out_valid, out, 1, data_out holds a new result.
- data_out, out, OUT_W, filtered, saturated result.
- sat, out, 1, data_out was clipped this result.

Function
REQ-003 Internal accumulator width SHALL be ACC_W = DATA_W + COEF_W + clog2(NTAPS); no intermediate truncation is permitted.
REQ-004 Stage 1 (tap register) SHALL shift data_in into tap[0] and tap[i] into tap[i+1] only on an edge where in_valid=1; taps SHALL hold when in_valid=0.
REQ-005 Stage 2 (product register) SHALL register prod[i] = tap[i] * active_coef[i] for all taps in parallel; v2 SHALL register the stage-1 valid.
REQ-006 Stage 3 (output register) SHALL register the sum of all prod[i], saturated to OUT_W; out_valid SHALL equal the registered v2.
REQ-007 A sample accepted at edge N SHALL produce its out_valid/data_out at edge N+2; throughput SHALL be one sample per clock.
REQ-008 If the sum exceeds 2^OUT_W-1, data_out SHALL be 2^OUT_W-1 and sat SHALL be 1; otherwise sat SHALL be 0.
REQ-009 When out_valid=0, data_out and sat SHALL hold their previous values.
REQ-010 Writes with coef_addr >= NTAPS SHALL be ignored.
REQ-011 Shadow writes SHALL NOT affect the active bank until coef_commit=1.
REQ-012 On commit at edge C, products registered at edge C+1 onward SHALL use the new coefficients.
REQ-013 When coef_we and coef_commit are both asserted in the same cycle, the written value SHALL be included in the committed bank.
REQ-014 Coefficient writes and commits SHALL be accepted regardless of in_valid; in-flight samples SHALL NOT be stalled or dropped.

Reset
REQ-015 While rst=1, the following SHALL clear to 0 asynchronously: all taps, products, v2, out_valid, data_out and sat.
REQ-016 While rst=1, both coefficient banks SHALL load COEF_INIT.
REQ-017 Reset mid-stream SHALL discard all in-flight samples; the first sample after reset sees zero history.

Structure
REQ-018 Package fir_pkg SHALL hold the clog2 function, the ACC_W derivation and the default COEF_INIT constant.
REQ-019 Sub-module fir_coef_bank SHALL own the shadow bank, the active bank, the write decode and commit, and SHALL expose the active bank as a flat vector.

Verification
REQ-020 Impulse: defaults; data_in=10 for one valid cycle, then zeros with in_valid=1 -> data_out = 10,20,30,20,10, then 0; first result 2 cycles after the impulse.
REQ-021 Saturation: OUT_W=10; constant 255 with in_valid=1 -> steady data_out=1023, sat=1 (true sum 2295).
REQ-022 Bubbles: impulse 10 with in_valid alternating 1/0 -> same 10,20,30,20,10 sequence; out_valid alternates; data_out holds during gaps.
REQ-023 Coefficient swap: stream constant 1; write all taps=4 (no visible change), then commit -> output steps from 9 to 20 exactly 2 edges after commit; a same-cycle write+commit of tap0=7 -> settles at 23.
REQ-024 Reset mid-stream: assert rst while out_valid=1 -> outputs 0 immediately; after release, impulse 5 -> 5,10,15,10,5 with COEF_INIT restored.
